uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 S_CLK, 50_000_000, system clock frequency in Hz.
REQ-002 BAUD, 115200, line bit rate; B_CNT = S_CLK/BAUD (integer divide), HALF = B_CNT>>1; B_CNT >= 8 required.
REQ-003 DATA_BITS, 8, data bits per frame, legal range 5..9.
REQ-004 PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 STOP_BITS, 1, stop bits per frame, 1 or 2.
REQ-006 sys_clk  input  1  system clock, all logic on rising edge.
REQ-007 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  1  asynchronous serial line, idle high.
REQ-009 rx_data  output  DATA_BITS  received word, LSB = first data bit on the line.
REQ-010 rx_valid  output  1  rx_data and error flags hold a frame.
REQ-011 rx_ready  input  1  consumer accepts the frame when high with rx_valid.
REQ-012 parity_err  output  1  parity mismatch for the held frame; 0 when PARITY=0.
REQ-013 frame_err  output  1  a stop bit of the held frame sampled low.
REQ-014 overrun  output  1  one-cycle pulse when a completed frame is discarded.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 data_in SHALL pass through a 2-flop synchroniser whose flops reset to 1, so reset release never creates a false start edge.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PAR, STOP; PAR is skipped when PARITY=0.
REQ-018 The bit-period counter SHALL run 0..B_CNT-1 in every non-IDLE state and clear to 0 on wrap and on entry to START.
REQ-019 Each bit value SHALL be the 2-of-3 majority of synchronised samples taken at counter values HALF-1, HALF, HALF+1, resolved at HALF+1.
REQ-020 IDLE -> START on a synchronised falling edge (previous 1, current 0).
REQ-021 START: voted value 1 -> IDLE (glitch rejected, no outputs change); voted 0 -> DATA at counter wrap.
REQ-022 DATA: one bit per period, shifted LSB-first; after DATA_BITS bits -> PAR or STOP at wrap.
REQ-023 PAR: expected bit = XOR of data bits (even) or its inverse (odd); mismatch latches internal parity error.
REQ-024 STOP: each of STOP_BITS bits voted; any voted 0 latches internal frame error.
REQ-025 Frame completion SHALL occur at the vote point (HALF+1) of the last stop bit; FSM returns to IDLE on the next cycle, without waiting for the remaining half bit.
REQ-026 On completion with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle, rx_data/parity_err/frame_err SHALL load the new frame and rx_valid SHALL be 1 on the next cycle (latency: 1 clock after the vote point).
REQ-027 On completion with rx_valid=1 and rx_ready=0, the new frame SHALL be discarded, held outputs remain unchanged, and overrun pulses high for exactly one cycle.
REQ-028 rx_valid SHALL clear on the cycle after rx_valid && rx_ready unless REQ-026 reloads it; rx_data and flags hold their value until reloaded.
REQ-029 Frames with parity_err or frame_err SHALL still be delivered via rx_valid with the flags set.
REQ-030 A falling edge while busy SHALL be ignored; edge detection applies only in IDLE.

Reset
REQ-031 sys_rst_n low SHALL immediately force FSM to IDLE, counters to 0, synchroniser to 1, rx_data to 0, and rx_valid, parity_err, frame_err, overrun, busy to 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no rx_valid or overrun; reception restarts at the next falling edge after release.

Verification (S_CLK=50_000_000, BAUD=115200, B_CNT=434, HALF=217)
REQ-033 8N1, send 0x55, rx_ready=1 -> rx_data=0x55, rx_valid pulses 1 cycle, parity_err=0, frame_err=0, busy low after completion.
REQ-034 8E1, send 0xA3 with parity bit 1 -> rx_data=0xA3, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-035 8N1, send 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1, rx_valid=1.
REQ-036 Low glitch of 100 clocks on idle line -> busy high then low by counter 218, no rx_valid; following 0x81 frame received correctly.
REQ-037 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun high exactly 1 cycle; rx_ready=1 then clears rx_valid.
REQ-038 Reset pulse during data bit 4 of 0xF0 -> all outputs 0, no rx_valid; next 0x0F frame received as 0x0F.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop input synchroniser, mid-bit 3-sample majority vote,
// optional parity and 1/2 stop bits, single-entry output holding register with overrun pulse.
module uart_rx_param #(
    parameter int S_CLK     = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int B_CNT = S_CLK / BAUD;
    localparam int HALF  = B_CNT >> 1;
    localparam int CW    = $clog2(B_CNT);
    localparam int BW    = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] C_LAST = CW'(B_CNT - 1);
    localparam logic [CW-1:0] C_HM1  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_HALF = CW'(HALF);
    localparam logic [CW-1:0] C_HP1  = CW'(HALF + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic                 sync1, sync2, prev;
    logic [CW-1:0]        cnt;
    logic                 s_a, s_b;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_idx;
    logic                 perr_r, ferr_r;

    logic fall, wrap, vote_pt, vote, par_exp, done, ferr_new;

    // Synchroniser and edge-history flops reset high so reset release cannot look like a start edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= data_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall     = prev & ~sync2;
    assign wrap     = (cnt == C_LAST);
    assign vote_pt  = (cnt == C_HP1);
    assign vote     = (s_a & s_b) | (s_a & sync2) | (s_b & sync2);
    assign par_exp  = (^shreg) ^ (PARITY == 1);
    assign done     = (state == STOP) && vote_pt && (stop_idx == 1'(STOP_BITS - 1));
    assign ferr_new = ferr_r | ~vote;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fall) state_nxt = START;
            START: begin
                if (vote_pt && vote) state_nxt = IDLE;
                else if (wrap)       state_nxt = DATA;
            end
            DATA:  if (wrap && bit_cnt == BW'(DATA_BITS)) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (wrap) state_nxt = STOP;
            STOP:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Counter sits at 0 throughout IDLE, so START always begins from 0
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
            s_a <= 1'b1;
            s_b <= 1'b1;
        end else begin
            if (state == IDLE || state_nxt == IDLE) cnt <= '0;
            else                                    cnt <= wrap ? '0 : cnt + CW'(1);
            if (cnt == C_HM1)  s_a <= sync2;
            if (cnt == C_HALF) s_b <= sync2;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
        end else if (state == IDLE) begin
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
        end else begin
            if (vote_pt) begin
                case (state)
                    DATA: begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                    PAR:  perr_r <= vote ^ par_exp;
                    STOP: if (!vote) ferr_r <= 1'b1;
                    default: ;
                endcase
            end
            if (state == STOP && wrap) stop_idx <= ~stop_idx;
        end
    end

    // Holding register: load when empty or being drained this cycle, otherwise drop and flag
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= perr_r;
                    frame_err  <= ferr_new;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
